// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: limits,
// history-fill width helper and parameter-range checks.
package seq_det_pkg;

  localparam int MAX_PATTERN_W = 32;
  localparam int MAX_CNT_W     = 32;

  // Width of a counter that must hold values 0..n-1.
  function automatic int fill_w(input int n);
    return $clog2(n);
  endfunction

  function automatic bit pattern_w_ok(input int n);
    return (n >= 2) && (n <= MAX_PATTERN_W);
  endfunction

  function automatic bit cnt_w_ok(input int n);
    return (n >= 1) && (n <= MAX_CNT_W);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-bit input and match-report outputs of the pattern detector.
interface seq_detector_param_if #(
  parameter int CNT_W = 8
);
  // Handshake: x is consumed on a rising clk edge exactly when in_valid=1;
  // there is no ready, the detector always accepts. clr overrides in_valid.
  logic             in_valid;
  logic             x;
  logic             clr;
  logic             z;
  logic             z_reg;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output in_valid, x, clr,
    input  z, z_reg, match_cnt, cnt_sat
  );

  modport slave (
    input  in_valid, x, clr,
    output z, z_reg, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: Mealy match z, registered z_reg and a
// saturating match counter. History restarts after a match when OVERLAP=0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(3'b101),
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  seq_detector_param_if.slave  bus
);

  if (!pattern_w_ok(PATTERN_W)) begin : g_bad_pattern_w
    $error("seq_detector_param: PATTERN_W=%0d outside 2..%0d", PATTERN_W, MAX_PATTERN_W);
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W=%0d outside 1..%0d", CNT_W, MAX_CNT_W);
  end

  localparam int            HW        = PATTERN_W - 1;
  localparam int            FW        = fill_w(PATTERN_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(HW);

  logic [HW-1:0]        hist, hist_nxt, hist_shift;
  logic [FW-1:0]        fill, fill_nxt;
  logic [PATTERN_W-1:0] win;
  logic                 accept;
  logic                 z_int;
  logic                 z_reg_q;

  assign accept = bus.in_valid & ~bus.clr;
  assign win    = {hist, bus.x};
  // fill and hist are zero in reset, so z is also held low then.
  assign z_int  = accept & (fill == FILL_FULL) & (win == PATTERN);

  if (HW == 1) begin : g_hist_one
    assign hist_shift = bus.x;
  end else begin : g_hist_many
    assign hist_shift = {hist[HW-2:0], bus.x};
  end

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (bus.clr) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (bus.in_valid) begin
      hist_nxt = hist_shift;
      fill_nxt = (fill == FILL_FULL) ? fill : fill + FW'(1);
      // Non-overlapping: the stale history is ignored until refilled.
      if (z_int && !OVERLAP) begin
        fill_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hist    <= '0;
      fill    <= '0;
      z_reg_q <= 1'b0;
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      z_reg_q <= bus.clr ? 1'b0 : z_int;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (bus.clr),
    .inc     (z_int),
    .cnt     (bus.match_cnt),
    .sat     (bus.cnt_sat)
  );

  assign bus.z     = z_int;
  assign bus.z_reg = z_reg_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios on 3-bit instances and a
// random stream on 8-bit instances checked against a queue-based model.
module tb_seq_detector_param;

  logic clk;
  logic aresetn;
  logic iv, xb, cl;
  int   checks   = 0;
  int   failures = 0;
  logic [1:0] exp_q[$];

  seq_detector_param_if #(.CNT_W(8)) d_if ();
  seq_detector_param_if #(.CNT_W(8)) n_if ();
  seq_detector_param_if #(.CNT_W(2)) c_if ();
  seq_detector_param_if #(.CNT_W(8)) a_if ();
  seq_detector_param_if #(.CNT_W(8)) b_if ();

  assign d_if.in_valid = iv;  assign d_if.x = xb;  assign d_if.clr = cl;
  assign n_if.in_valid = iv;  assign n_if.x = xb;  assign n_if.clr = cl;
  assign c_if.in_valid = iv;  assign c_if.x = xb;  assign c_if.clr = cl;
  assign a_if.in_valid = iv;  assign a_if.x = xb;  assign a_if.clr = cl;
  assign b_if.in_valid = iv;  assign b_if.x = xb;  assign b_if.clr = cl;

  seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8))
    u_def (.clk(clk), .aresetn(aresetn), .bus(d_if));
  seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8))
    u_nov (.clk(clk), .aresetn(aresetn), .bus(n_if));
  seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2))
    u_c2  (.clk(clk), .aresetn(aresetn), .bus(c_if));
  seq_detector_param #(.PATTERN_W(8), .PATTERN(8'hA5), .OVERLAP(1'b1), .CNT_W(8))
    u_w8o (.clk(clk), .aresetn(aresetn), .bus(a_if));
  seq_detector_param #(.PATTERN_W(8), .PATTERN(8'hA5), .OVERLAP(1'b0), .CNT_W(8))
    u_w8n (.clk(clk), .aresetn(aresetn), .bus(b_if));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic apply(input logic v, input logic b, input logic c);
    @(negedge clk);
    iv = v; xb = b; cl = c;
    #1;
  endtask

  // ---------------- reference model ----------------
  // q holds accepted bits oldest first; a hit is the last 7 bits plus b equal to A5.
  function automatic logic model_hit(input bit q[$], input logic b);
    logic [7:0] p;
    p = 8'hA5;
    if (q.size() < 7) return 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (q[q.size() - 7 + i] != p[7 - i]) return 1'b0;
    end
    return b == p[0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b0);
    checks++; if (d_if.z !== 1'b0) begin failures++; $display("FAIL rst_z got=%b exp=0", d_if.z); end
    checks++; if (d_if.z_reg !== 1'b0) begin failures++; $display("FAIL rst_zreg got=%b exp=0", d_if.z_reg); end
    checks++; if (d_if.match_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", d_if.match_cnt); end
    checks++; if (c_if.cnt_sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", c_if.cnt_sat); end
    aresetn = 1'b1;
    apply(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overlap();
    logic [7:0] s, e_d, e_n;
    logic pd, pn;
    int cd, cn;
    s = 8'b10101101; e_d = 8'b00101001; e_n = 8'b00100001;
    pd = 1'b0; pn = 1'b0; cd = 0; cn = 0;
    apply(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, s[7-k], 1'b0);
      checks++; if (d_if.z !== e_d[7-k]) begin failures++; $display("FAIL ovl_z bit%0d got=%b exp=%b", k+1, d_if.z, e_d[7-k]); end
      checks++; if (n_if.z !== e_n[7-k]) begin failures++; $display("FAIL novl_z bit%0d got=%b exp=%b", k+1, n_if.z, e_n[7-k]); end
      checks++; if (d_if.z_reg !== pd) begin failures++; $display("FAIL ovl_zreg bit%0d got=%b exp=%b", k+1, d_if.z_reg, pd); end
      checks++; if (n_if.z_reg !== pn) begin failures++; $display("FAIL novl_zreg bit%0d got=%b exp=%b", k+1, n_if.z_reg, pn); end
      checks++; if (d_if.match_cnt !== 8'(cd)) begin failures++; $display("FAIL ovl_cnt bit%0d got=%0d exp=%0d", k+1, d_if.match_cnt, cd); end
      checks++; if (n_if.match_cnt !== 8'(cn)) begin failures++; $display("FAIL novl_cnt bit%0d got=%0d exp=%0d", k+1, n_if.match_cnt, cn); end
      pd = e_d[7-k]; pn = e_n[7-k];
      cd += int'(pd); cn += int'(pn);
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++; if (d_if.match_cnt !== 8'd3) begin failures++; $display("FAIL ovl_cnt_final got=%0d exp=3", d_if.match_cnt); end
    checks++; if (n_if.match_cnt !== 8'd2) begin failures++; $display("FAIL novl_cnt_final got=%0d exp=2", n_if.match_cnt); end
    checks++; if (d_if.z_reg !== 1'b1) begin failures++; $display("FAIL ovl_zreg_final got=%b exp=1", d_if.z_reg); end
  endtask

  task automatic test_gap();
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0);
      checks++; if (d_if.z !== 1'b0) begin failures++; $display("FAIL gap_z cyc%0d got=%b exp=0", k, d_if.z); end
      checks++; if (d_if.z_reg !== 1'b0) begin failures++; $display("FAIL gap_zreg cyc%0d got=%b exp=0", k, d_if.z_reg); end
    end
    apply(1'b1, 1'b1, 1'b0);
    checks++; if (d_if.z !== 1'b1) begin failures++; $display("FAIL gap_match got=%b exp=1", d_if.z); end
    apply(1'b0, 1'b0, 1'b0);
    checks++; if (d_if.match_cnt !== 8'd1) begin failures++; $display("FAIL gap_cnt got=%0d exp=1", d_if.match_cnt); end
  endtask

  task automatic test_clr();
    logic [4:0] s, e;
    s = 5'b01101; e = 5'b00001;
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    checks++; if (d_if.z !== 1'b0) begin failures++; $display("FAIL clr_z got=%b exp=0", d_if.z); end
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, s[4-k], 1'b0);
      if (k == 0) begin
        checks++; if (d_if.match_cnt !== 8'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", d_if.match_cnt); end
        checks++; if (d_if.z_reg !== 1'b0) begin failures++; $display("FAIL clr_zreg got=%b exp=0", d_if.z_reg); end
      end
      checks++; if (d_if.z !== e[4-k]) begin failures++; $display("FAIL clr_after_z bit%0d got=%b exp=%b", k, d_if.z, e[4-k]); end
    end
  endtask

  task automatic test_sat();
    int m, ec;
    apply(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k < 11) apply(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      else        apply(1'b0, 1'b0, 1'b0);
      m  = (k >= 3) ? (k - 1) / 2 : 0;
      ec = (m > 3) ? 3 : m;
      checks++; if (c_if.match_cnt !== 2'(ec)) begin failures++; $display("FAIL sat_cnt cyc%0d got=%0d exp=%0d", k, c_if.match_cnt, ec); end
      checks++; if (c_if.cnt_sat !== (ec == 3)) begin failures++; $display("FAIL sat_flag cyc%0d got=%b exp=%b", k, c_if.cnt_sat, ec == 3); end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] s;
    s = 5'b10110;
    apply(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) apply(1'b1, s[4-k], 1'b0);
    @(negedge clk);
    iv = 1'b1; xb = 1'b1; cl = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++; if (d_if.z !== 1'b0) begin failures++; $display("FAIL ares_z got=%b exp=0", d_if.z); end
    checks++; if (d_if.match_cnt !== 8'd0) begin failures++; $display("FAIL ares_cnt got=%0d exp=0", d_if.match_cnt); end
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    checks++; if (d_if.z !== 1'b0) begin failures++; $display("FAIL ares_after_z got=%b exp=0", d_if.z); end
    apply(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit   qa[$], qb[$];
    int   ca, cb;
    logic v, b, c, za, zb;
    logic [1:0] e;
    ca = 0; cb = 0;
    exp_q.delete();
    apply(1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 10000; n++) begin
      if (n < 10000) begin
        v = ($urandom_range(0, 3) != 0);
        b = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 499) == 0);
      end else begin
        v = 1'b0; b = 1'b0; c = 1'b0;
      end
      apply(v, b, c);
      za = v & ~c & model_hit(qa, b);
      zb = v & ~c & model_hit(qb, b);
      checks++; if (a_if.z !== za) begin failures++; $display("FAIL rnd_ovl_z n=%0d got=%b exp=%b", n, a_if.z, za); end
      checks++; if (b_if.z !== zb) begin failures++; $display("FAIL rnd_novl_z n=%0d got=%b exp=%b", n, b_if.z, zb); end
      checks++; if (a_if.match_cnt !== 8'(ca)) begin failures++; $display("FAIL rnd_ovl_cnt n=%0d got=%0d exp=%0d", n, a_if.match_cnt, ca); end
      checks++; if (b_if.match_cnt !== 8'(cb)) begin failures++; $display("FAIL rnd_novl_cnt n=%0d got=%0d exp=%0d", n, b_if.match_cnt, cb); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if ({a_if.z_reg, b_if.z_reg} !== e) begin failures++; $display("FAIL rnd_zreg n=%0d got=%b%b exp=%b", n, a_if.z_reg, b_if.z_reg, e); end
      end
      exp_q.push_back({za, zb});
      if (c) begin
        qa.delete(); qb.delete(); ca = 0; cb = 0;
      end else begin
        if (v) begin qa.push_back(b); qb.push_back(b); end
        if (zb) qb.delete();
        if (qa.size() > 8) void'(qa.pop_front());
        if (qb.size() > 8) void'(qb.pop_front());
        if (za && ca < 255) ca++;
        if (zb && cb < 255) cb++;
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    aresetn = 1'b0;
    iv = 1'b0; xb = 1'b0; cl = 1'b0;
    test_reset();
    test_overlap();
    test_gap();
    test_clr();
    test_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
